stopwatch_lap_ctrl: RTL and testbench

Control unit for the stopwatch datapath with lap-time capture. Accepts debounced single-cycle button pulses for run/stop, clear and lap. Drives the datapath's run_stop level and clear pulse. Sits between the live msec/sec/min/hour outputs of the datapath and the FND controller, and substitutes a frozen lap snapshot on the display while the counter keeps running.

---
 rtl/stopwatch_pkg.sv | 35 +++
 rtl/stopwatch_lap_reg.sv | 53 +++++
 rtl/stopwatch_lap_ctrl.sv | 141 ++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
// Build option: define LAP_TIMEOUT_EN to make a lap snapshot return to live
// time by itself after LAP_HOLD_CYCLES clock cycles.
package stopwatch_pkg;

    // Field widths of the datapath time value
    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Default snapshot display time: 3 s at 100 MHz
    localparam int unsigned LAP_HOLD_CYCLES_DEFAULT = 300_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_e;

    // One complete time value as shown on the display
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } time_t;

    // Width of a counter that reaches cycles-1, never narrower than one bit
    function automatic int unsigned hold_cnt_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/stopwatch_lap_reg.sv
// Four-field lap snapshot register and the display mux.
// The snapshot loads when load_i is high; sel_i chooses the snapshot
// over the live time. When sel_i is low the live fields pass straight
// through, with no register in the path.
module stopwatch_lap_reg
    import stopwatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              sel_i,
    input  logic [MSEC_W-1:0] msec_i,
    input  logic [SEC_W-1:0]  sec_i,
    input  logic [MIN_W-1:0]  min_i,
    input  logic [HOUR_W-1:0] hour_i,
    output logic [MSEC_W-1:0] msec_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [HOUR_W-1:0] hour_o
);

    time_t snap_q;

    // Capture the live time on the lap event
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the snapshot is only four fields wide, so clearing it on
        // reset is cheap. This makes its value defined after reset.
        if (!rst_n) begin
            snap_q <= '0;
        end else if (load_i) begin
            // NOTE: use non-blocking assignments for every register so that
            // all flops update together and simulation matches the netlist.
            snap_q <= '{hour: hour_i, min: min_i, sec: sec_i, msec: msec_i};
        end
    end

    // Display mux: the frozen snapshot or the live pass-through
    always_comb begin
        // NOTE: each output gets a value on every path. A missing branch
        // would otherwise infer a latch.
        msec_o = msec_i;
        sec_o  = sec_i;
        min_o  = min_i;
        hour_o = hour_i;
        if (sel_i) begin
            msec_o = snap_q.msec;
            sec_o  = snap_q.sec;
            min_o  = snap_q.min;
            hour_o = snap_q.hour;
        end
    end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM with lap-time capture.
// This block turns the run/stop, clear and lap pulses into the datapath
// count enable and a clear pulse. While the counter keeps running, it can
// put a frozen lap snapshot on the display in place of the live time.
// Build option: LAP_TIMEOUT_EN adds a hold counter. The counter returns
// the display to live time after LAP_HOLD_CYCLES cycles in LAP.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
`ifdef LAP_TIMEOUT_EN
#(
    parameter int unsigned LAP_HOLD_CYCLES = LAP_HOLD_CYCLES_DEFAULT
)
`endif
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_runstop,
    input  logic              i_clear,
    input  logic              i_lap,
    input  logic [MSEC_W-1:0] i_msec,
    input  logic [SEC_W-1:0]  i_sec,
    input  logic [MIN_W-1:0]  i_min,
    input  logic [HOUR_W-1:0] i_hour,
    output logic              o_runstop,
    output logic              o_clear,
    output logic              o_lap_active,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour
);

    state_e state_q, state_d;
    logic   clear_q, clear_d;
    logic   timeout;
    logic   load_snap;

    // State and registered clear pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
        end
    end

    // Next-state logic. Within each state the order is clear, then
    // runstop, then lap. At most one event is acted on per cycle.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_clear) begin
                    clear_d = 1'b1;
                end else if (i_runstop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_runstop) begin
                    state_d = STOP;
                end else if (i_lap) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (i_runstop) begin
                    state_d = STOP;
                end else if (i_lap || timeout) begin
                    state_d = RUN;
                end
            end
            STOP: begin
                if (i_clear) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end else if (i_runstop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        o_runstop    = (state_q == RUN) || (state_q == LAP);
        o_lap_active = (state_q == LAP);
        o_clear      = clear_q;
    end

    // Capture only on the RUN -> LAP transition; a lap that exits LAP never loads
    assign load_snap = (state_q == RUN) && (state_d == LAP);

`ifdef LAP_TIMEOUT_EN
    localparam int unsigned CNT_W = hold_cnt_w(LAP_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAP_HOLD_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Count cycles spent in LAP; zero on entry and everywhere outside LAP
    always_comb begin
        hold_cnt_d = '0;
        if ((state_q == LAP) && (state_d == LAP)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Hold counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign timeout = (state_q == LAP) && (hold_cnt_q == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    stopwatch_lap_reg u_lap_reg (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (load_snap),
        .sel_i  (o_lap_active),
        .msec_i (i_msec),
        .sec_i  (i_sec),
        .min_i  (i_min),
        .hour_i (i_hour),
        .msec_o (o_msec),
        .sec_o  (o_sec),
        .min_o  (o_min),
        .hour_o (o_hour)
    );

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed testbench for stopwatch_lap_ctrl. Inputs change on the falling
// clock edge and outputs are sampled there, half a cycle after the rising
// edge that changed them.
module tb_stopwatch_lap_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_runstop, i_clear, i_lap;
    logic [6:0] i_msec;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [4:0] i_hour;
    logic       o_runstop, o_clear, o_lap_active;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef LAP_TIMEOUT_EN
    stopwatch_lap_ctrl #(.LAP_HOLD_CYCLES(10)) dut (
`else
    stopwatch_lap_ctrl dut (
`endif
        .clk          (clk),
        .reset        (reset),
        .i_runstop    (i_runstop),
        .i_clear      (i_clear),
        .i_lap        (i_lap),
        .i_msec       (i_msec),
        .i_sec        (i_sec),
        .i_min        (i_min),
        .i_hour       (i_hour),
        .o_runstop    (o_runstop),
        .o_clear      (o_clear),
        .o_lap_active (o_lap_active),
        .o_msec       (o_msec),
        .o_sec        (o_sec),
        .o_min        (o_min),
        .o_hour       (o_hour)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle pulse on any combination of the three buttons
    task automatic pulse(input logic rs, input logic cl, input logic lp);
        @(negedge clk);
        i_runstop = rs;
        i_clear   = cl;
        i_lap     = lp;
        @(negedge clk);
        i_runstop = 1'b0;
        i_clear   = 1'b0;
        i_lap     = 1'b0;
    endtask

    task automatic set_time(input logic [6:0] ms, input logic [5:0] s,
                            input logic [5:0] m, input logic [4:0] h);
        i_msec = ms;
        i_sec  = s;
        i_min  = m;
        i_hour = h;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        i_runstop = 1'b0;
        i_clear   = 1'b0;
        i_lap     = 1'b0;
        set_time(7'd0, 6'd5, 6'd0, 5'd0);

        // Reset values while reset is held
        #12;
        check("rst_runstop", 32'(o_runstop), 32'd0);
        check("rst_clear", 32'(o_clear), 32'd0);
        check("rst_lap_active", 32'(o_lap_active), 32'd0);
        check("rst_sec_pass", 32'(o_sec), 32'd5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_runstop", 32'(o_runstop), 32'd0);

        // Run, then stop
        pulse(1'b1, 1'b0, 1'b0);
        check("run_runstop", 32'(o_runstop), 32'd1);
        check("run_lap_active", 32'(o_lap_active), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check("stop_runstop", 32'(o_runstop), 32'd0);

        // Clear in STOP: exactly one cycle of o_clear
        pulse(1'b0, 1'b1, 1'b0);
        check("stop_clear_hi", 32'(o_clear), 32'd1);
        check("stop_clear_run", 32'(o_runstop), 32'd0);
        @(negedge clk);
        check("stop_clear_lo", 32'(o_clear), 32'd0);

        // Clear in RUN is ignored
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("run_clear_none", 32'(o_clear), 32'd0);
        check("run_clear_keep", 32'(o_runstop), 32'd1);

        // Lap capture in RUN
        set_time(7'd42, 6'd17, 6'd3, 5'd1);
        pulse(1'b0, 1'b0, 1'b1);
        check("lap_active", 32'(o_lap_active), 32'd1);
        check("lap_runstop", 32'(o_runstop), 32'd1);
        set_time(7'd50, 6'd20, 6'd4, 5'd2);
        #1;
        check("lap_msec", 32'(o_msec), 32'd42);
        check("lap_sec", 32'(o_sec), 32'd17);
        check("lap_min", 32'(o_min), 32'd3);
        check("lap_hour", 32'(o_hour), 32'd1);
        @(negedge clk);
        set_time(7'd51, 6'd21, 6'd5, 5'd3);
        #1;
        check("lap_hold_msec", 32'(o_msec), 32'd42);
        check("lap_hold_hour", 32'(o_hour), 32'd1);

        // Second lap returns to live display
        pulse(1'b0, 1'b0, 1'b1);
        check("unlap_active", 32'(o_lap_active), 32'd0);
        check("unlap_runstop", 32'(o_runstop), 32'd1);
        check("unlap_msec_live", 32'(o_msec), 32'd51);
        check("unlap_min_live", 32'(o_min), 32'd5);

        // runstop + lap in RUN: runstop wins, giving STOP with no lap display
        set_time(7'd77, 6'd30, 6'd6, 5'd4);
        pulse(1'b1, 1'b0, 1'b1);
        check("rs_lap_runstop", 32'(o_runstop), 32'd0);
        check("rs_lap_active", 32'(o_lap_active), 32'd0);
        check("rs_lap_msec", 32'(o_msec), 32'd77);

        // clear + runstop in STOP: clear wins
        pulse(1'b1, 1'b1, 1'b0);
        check("cl_rs_clear_hi", 32'(o_clear), 32'd1);
        check("cl_rs_runstop", 32'(o_runstop), 32'd0);
        @(negedge clk);
        check("cl_rs_clear_lo", 32'(o_clear), 32'd0);

        // Lap in IDLE is ignored
        pulse(1'b0, 1'b0, 1'b1);
        check("idle_lap_active", 32'(o_lap_active), 32'd0);
        check("idle_lap_runstop", 32'(o_runstop), 32'd0);

        // A held runstop acts on each cycle: IDLE -> RUN -> STOP
        @(negedge clk);
        i_runstop = 1'b1;
        @(negedge clk);
        check("held_rs_first", 32'(o_runstop), 32'd1);
        @(negedge clk);
        i_runstop = 1'b0;
        check("held_rs_second", 32'(o_runstop), 32'd0);

        // Reset asserted asynchronously in LAP
        pulse(1'b1, 1'b0, 1'b0);
        set_time(7'd10, 6'd11, 6'd12, 5'd13);
        pulse(1'b0, 1'b0, 1'b1);
        check("pre_rst_lap", 32'(o_lap_active), 32'd1);
        set_time(7'd20, 6'd21, 6'd22, 5'd14);
        #1;
        check("pre_rst_snap", 32'(o_msec), 32'd10);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_lap", 32'(o_lap_active), 32'd0);
        check("mid_rst_runstop", 32'(o_runstop), 32'd0);
        check("mid_rst_clear", 32'(o_clear), 32'd0);
        check("mid_rst_msec", 32'(o_msec), 32'd20);
        check("mid_rst_hour", 32'(o_hour), 32'd14);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_runstop", 32'(o_runstop), 32'd0);

`ifdef LAP_TIMEOUT_EN
        // The lap display holds for exactly 10 cycles, then returns to RUN
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("to_hold_%0d", i), 32'(o_lap_active), 32'd1);
            @(negedge clk);
        end
        check("to_expired", 32'(o_lap_active), 32'd0);
        check("to_run", 32'(o_runstop), 32'd1);

        // Entering LAP again starts the count over from 0
        pulse(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        check("to_exit_early", 32'(o_lap_active), 32'd0);
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("to_rehold_%0d", i), 32'(o_lap_active), 32'd1);
            @(negedge clk);
        end
        check("to_reexpired", 32'(o_lap_active), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
